// File: rtl/proc_pkg.sv
// Shared processor package: width helper and branch-counter init constants.
package proc_pkg;

   // Ceiling log2 for parameter arithmetic; returns at least 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      if (res == 0) res = 1;
      return res;
   endfunction

   // Weakly-taken counter value: MSB set, all lower bits clear.
   function automatic int unsigned ctr_wt(input int unsigned ctr_wid);
      return 32'd1 << (ctr_wid - 1);
   endfunction

   // Weakly-not-taken counter value: one below weakly-taken.
   function automatic int unsigned ctr_wnt(input int unsigned ctr_wid);
      return ctr_wt(ctr_wid) - 1;
   endfunction

   typedef enum logic {
      BHT_IDLE  = 1'b0,
      BHT_CLEAR = 1'b1
   } bht_state_e;

endpackage

// File: rtl/bht_sat_ctr.sv
// Combinational next-state for a saturating up/down prediction counter.
module bht_sat_ctr #(
   parameter int unsigned CTR_WID = 2
) (
   input  logic [CTR_WID-1:0] ctr_q,
   input  logic               up,
   output logic [CTR_WID-1:0] ctr_d
);

   // Step toward the outcome, holding at either rail.
   always_comb begin
      ctr_d = ctr_q;
      if (up) begin
         if (ctr_q != '1) ctr_d = ctr_q + 1'b1;
      end else begin
         if (ctr_q != '0) ctr_d = ctr_q - 1'b1;
      end
   end

endmodule

// File: rtl/ctrl_branch_bht.sv
// Branch history table / target buffer with sweep-clear and perf counters.
module ctrl_branch_bht
   import proc_pkg::*;
#(
   parameter int unsigned PROG_CTR_WID = 10,
   parameter int unsigned BHT_DEPTH    = 16,
   parameter int unsigned CTR_WID      = 2,
   parameter int unsigned STAT_WID     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    lkp_valid,
   input  logic [PROG_CTR_WID-1:0] lkp_pc,
   output logic                    pred_taken,
   output logic [PROG_CTR_WID-1:0] pred_target,
   input  logic                    upd_valid,
   input  logic [PROG_CTR_WID-1:0] upd_pc,
   input  logic                    upd_taken,
   input  logic [PROG_CTR_WID-1:0] upd_target,
   input  logic                    upd_pred_taken,
   input  logic [PROG_CTR_WID-1:0] upd_pred_target,
   output logic                    flush,
   output logic [PROG_CTR_WID-1:0] redirect_pc,
   input  logic                    clr_req,
   output logic                    clr_busy,
   output logic [STAT_WID-1:0]     lookup_cnt,
   output logic [STAT_WID-1:0]     mispred_cnt
);

   localparam int unsigned IDX   = clog2(BHT_DEPTH);
   localparam int unsigned TAG_W = PROG_CTR_WID - IDX;
   localparam logic [CTR_WID-1:0] WT  = CTR_WID'(ctr_wt(CTR_WID));
   localparam logic [CTR_WID-1:0] WNT = CTR_WID'(ctr_wnt(CTR_WID));
   localparam logic [IDX-1:0] PTR_LAST = IDX'(BHT_DEPTH - 1);

   logic                    ent_valid  [BHT_DEPTH];
   logic [TAG_W-1:0]        ent_tag    [BHT_DEPTH];
   logic [PROG_CTR_WID-1:0] ent_target [BHT_DEPTH];
   logic [CTR_WID-1:0]      ent_ctr    [BHT_DEPTH];

   bht_state_e     state;
   logic [IDX-1:0] ptr;

   logic [IDX-1:0]     lkp_idx;
   logic [TAG_W-1:0]   lkp_tag;
   logic               lkp_hit;
   logic [IDX-1:0]     upd_idx;
   logic [TAG_W-1:0]   upd_tag;
   logic               upd_hit;
   logic               upd_en;
   logic               lkp_en;
   logic [CTR_WID-1:0] ctr_next;

   assign lkp_idx  = lkp_pc[IDX-1:0];
   assign lkp_tag  = lkp_pc[PROG_CTR_WID-1:IDX];
   assign upd_idx  = upd_pc[IDX-1:0];
   assign upd_tag  = upd_pc[PROG_CTR_WID-1:IDX];
   assign clr_busy = (state == BHT_CLEAR);
   assign lkp_en   = lkp_valid & ~clr_busy;
   assign upd_en   = upd_valid & ~clr_busy;
   assign lkp_hit  = ent_valid[lkp_idx] & (ent_tag[lkp_idx] == lkp_tag);
   assign upd_hit  = ent_valid[upd_idx] & (ent_tag[upd_idx] == upd_tag);

   // Zero-latency prediction straight from the table contents.
   always_comb begin
      pred_taken  = lkp_en & lkp_hit & ent_ctr[lkp_idx][CTR_WID-1];
      pred_target = pred_taken ? ent_target[lkp_idx] : '0;
   end

   // Mispredict detection and corrected fetch address from the EX outcome;
   // flush is forced low while reset is held.
   always_comb begin
      flush = reset & upd_valid &
              ((upd_taken != upd_pred_taken) |
               (upd_taken & (upd_target != upd_pred_target)));
      redirect_pc = upd_taken ? upd_target : upd_pc + 1'b1;
   end

   bht_sat_ctr #(
      .CTR_WID(CTR_WID)
   ) u_sat_ctr (
      .ctr_q(ent_ctr[upd_idx]),
      .up   (upd_taken),
      .ctr_d(ctr_next)
   );

   // Sweep-clear sequencer: one entry per cycle, ignores requests mid-sweep.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= BHT_IDLE;
         ptr   <= '0;
      end else begin
         case (state)
            BHT_IDLE: begin
               if (clr_req) begin
                  state <= BHT_CLEAR;
                  ptr   <= '0;
               end
            end
            BHT_CLEAR: begin
               if (ptr == PTR_LAST) begin
                  state <= BHT_IDLE;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: begin
               state <= BHT_IDLE;
               ptr   <= '0;
            end
         endcase
      end
   end

   // Table storage: sweep invalidation has priority, otherwise train/allocate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
            ent_valid[i]  <= 1'b0;
            ent_tag[i]    <= '0;
            ent_target[i] <= '0;
            ent_ctr[i]    <= WNT;
         end
      end else if (clr_busy) begin
         ent_valid[ptr] <= 1'b0;
      end else if (upd_en) begin
         if (upd_hit) begin
            ent_ctr[upd_idx] <= ctr_next;
            if (upd_taken) ent_target[upd_idx] <= upd_target;
         end else if (upd_taken) begin
            ent_valid[upd_idx]  <= 1'b1;
            ent_tag[upd_idx]    <= upd_tag;
            ent_target[upd_idx] <= upd_target;
            ent_ctr[upd_idx]    <= WT;
         end
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lookup_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (lkp_en && (lookup_cnt != '1))  lookup_cnt  <= lookup_cnt + 1'b1;
         if (flush && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ctrl_branch_bht.sv
// Directed self-checking bench for ctrl_branch_bht (default parameters).
module tb_ctrl_branch_bht;

   logic        clk = 1'b0;
   logic        reset;
   logic        lkp_valid;
   logic [9:0]  lkp_pc;
   logic        pred_taken;
   logic [9:0]  pred_target;
   logic        upd_valid;
   logic [9:0]  upd_pc;
   logic        upd_taken;
   logic [9:0]  upd_target;
   logic        upd_pred_taken;
   logic [9:0]  upd_pred_target;
   logic        flush;
   logic [9:0]  redirect_pc;
   logic        clr_req;
   logic        clr_busy;
   logic [15:0] lookup_cnt;
   logic [15:0] mispred_cnt;

   int checks = 0;
   int errors = 0;
   int exp_lkp = 0;
   int exp_mis = 0;
   bit in_sweep = 0;
   int n;

   always #5 clk = ~clk;

   ctrl_branch_bht #(
      .PROG_CTR_WID(10),
      .BHT_DEPTH   (16),
      .CTR_WID     (2),
      .STAT_WID    (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .lkp_valid      (lkp_valid),
      .lkp_pc         (lkp_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_pred_taken (upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .flush          (flush),
      .redirect_pc    (redirect_pc),
      .clr_req        (clr_req),
      .clr_busy       (clr_busy),
      .lookup_cnt     (lookup_cnt),
      .mispred_cnt    (mispred_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; expected lookup count follows accepted lookups.
   task automatic step();
      if (lkp_valid && !in_sweep) exp_lkp++;
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [9:0] pc, input logic tk, input logic [9:0] tgt,
                      input logic ptk, input logic [9:0] ptgt);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      upd_pred_taken = ptk; upd_pred_target = ptgt;
   endtask

   task automatic look(input string tag, input logic [9:0] pc, input logic tk, input logic [9:0] tgt);
      lkp_valid = 1'b1; lkp_pc = pc;
      #1;
      check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
      check({tag, "_target"}, {22'd0, pred_target}, {22'd0, tgt});
   endtask

   initial begin
      reset = 1'b0; lkp_valid = 1'b0; lkp_pc = '0; clr_req = 1'b0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      upd_pred_taken = 1'b0; upd_pred_target = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Reset state plus first-allocation mispredict in the same cycle
      upd(10'h005, 1'b1, 10'h120, 1'b0, 10'h000);
      look("rst_lkp", 10'h005, 1'b0, 10'h000);
      check("rst_lkp_cnt", lookup_cnt, 0);
      check("rst_mis_cnt", mispred_cnt, 0);
      check("rst_busy", clr_busy, 0);
      check("alloc_flush", flush, 1);
      check("alloc_redir", redirect_pc, 10'h120);
      exp_mis++;
      step();
      look("alloc_hit", 10'h005, 1'b1, 10'h120);
      check("alloc_mis_cnt", mispred_cnt, exp_mis);
      check("alloc_lkp_cnt", lookup_cnt, exp_lkp);

      // Not-taken mispredict: 2 -> 1, redirect to fall-through
      upd(10'h005, 1'b0, 10'h000, 1'b1, 10'h120);
      #1;
      check("nt_flush", flush, 1);
      check("nt_redir", redirect_pc, 10'h006);
      exp_mis++;
      step();
      look("ctr1", 10'h005, 1'b0, 10'h000);
      upd(10'h005, 1'b0, 10'h000, 1'b0, 10'h000);
      #1 check("nt_ok_flush", flush, 0);
      step();
      look("ctr0", 10'h005, 1'b0, 10'h000);

      // Four taken updates: 0 -> 1 -> 2 -> 3 -> 3, then one not-taken -> 2
      upd(10'h005, 1'b1, 10'h120, 1'b1, 10'h120);
      #1 check("tk_ok_flush", flush, 0);
      step();
      look("inc1", 10'h005, 1'b0, 10'h000);
      step();
      look("inc2", 10'h005, 1'b1, 10'h120);
      step();
      step();
      upd(10'h005, 1'b0, 10'h000, 1'b0, 10'h000);
      step();
      look("sat_dec", 10'h005, 1'b1, 10'h120);
      upd_valid = 1'b0;
      check("mid_lkp_cnt", lookup_cnt, exp_lkp);
      check("mid_mis_cnt", mispred_cnt, exp_mis);

      // Aliasing: 0x015 shares index 5 with a different tag
      upd(10'h015, 1'b1, 10'h200, 1'b0, 10'h000);
      exp_mis++;
      step();
      upd_valid = 1'b0;
      look("alias_old", 10'h005, 1'b0, 10'h000);
      look("alias_new", 10'h015, 1'b1, 10'h200);

      // Not-taken mispredict at top of PC space wraps to 0
      upd(10'h3FF, 1'b0, 10'h000, 1'b1, 10'h050);
      #1;
      check("wrap_flush", flush, 1);
      check("wrap_redir", redirect_pc, 10'h000);
      exp_mis++;
      step();

      // Wrong target with correct direction also mispredicts
      upd(10'h00A, 1'b1, 10'h033, 1'b1, 10'h034);
      #1 check("tgt_flush", flush, 1);
      exp_mis++;
      step();
      upd_valid = 1'b0;
      look("pop_0a", 10'h00A, 1'b1, 10'h033);

      // Sweep with a simultaneous update in IDLE
      clr_req = 1'b1;
      upd(10'h007, 1'b1, 10'h044, 1'b1, 10'h044);
      step();
      clr_req = 1'b0;
      in_sweep = 1;
      upd(10'h00C, 1'b1, 10'h099, 1'b0, 10'h000);
      look("sweep_lkp", 10'h007, 1'b0, 10'h000);
      check("sweep_busy", clr_busy, 1);
      check("sweep_flush", flush, 1);
      exp_mis++;
      step();
      upd_valid = 1'b0;
      n = 1;
      while (clr_busy && n < 40) begin
         n++;
         step();
      end
      check("sweep_len", n, 16);
      in_sweep = 0;
      look("clr_07", 10'h007, 1'b0, 10'h000);
      look("clr_0c", 10'h00C, 1'b0, 10'h000);
      look("clr_15", 10'h015, 1'b0, 10'h000);
      look("clr_0a", 10'h00A, 1'b0, 10'h000);
      check("sweep_lkp_cnt", lookup_cnt, exp_lkp);
      check("sweep_mis_cnt", mispred_cnt, exp_mis);

      // Updates resume after the sweep
      upd(10'h00C, 1'b1, 10'h099, 1'b0, 10'h000);
      exp_mis++;
      step();
      upd_valid = 1'b0;
      look("resume_0c", 10'h00C, 1'b1, 10'h099);
      check("resume_mis_cnt", mispred_cnt, exp_mis);

      // Reset asserted in the 5th cycle of a sweep
      lkp_valid = 1'b0;
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      in_sweep = 1;
      repeat (4) step();
      check("rst_sweep_busy", clr_busy, 1);
      reset = 1'b0;
      upd(10'h000, 1'b1, 10'h010, 1'b0, 10'h000);
      look("rst2_lkp", 10'h00C, 1'b0, 10'h000);
      check("rst2_busy", clr_busy, 0);
      check("rst2_lkp_cnt", lookup_cnt, 0);
      check("rst2_mis_cnt", mispred_cnt, 0);
      check("rst2_flush", flush, 0);
      check("rst2_redir", redirect_pc, 10'h010);
      step();
      reset = 1'b1;
      upd_valid = 1'b0;
      in_sweep = 0;
      exp_lkp = 0;
      exp_mis = 0;
      look("post_rst_lkp", 10'h00C, 1'b0, 10'h000);
      step();
      check("post_rst_busy", clr_busy, 0);
      check("post_rst_lkp_cnt", lookup_cnt, exp_lkp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_branch_bht.md
# ctrl_branch_bht

Parametrised branch history table and target buffer. It is the successor to the combinational condition-based branch predictor. It sits beside `ctrl_ProgCtr`: it is looked up with the fetch PC in IF and updated with resolved outcomes from EX. It provides a predicted next PC, a mispredict flush/redirect, and a sweep-clear mode. It also keeps saturating performance counters.

## Interface
Parameters:
- PROG_CTR_WID, 10, program counter width
- BHT_DEPTH, 16, number of entries; power of two, 2..256
- CTR_WID, 2, saturating counter width, 1..4
- STAT_WID, 16, performance counter width

Ports:
- clk, input, 1, the single clock
- reset, input, 1, asynchronous, active-low
- lkp_valid, input, 1, IF lookup request
- lkp_pc, input, PROG_CTR_WID, fetch PC
- pred_taken, output, 1, predict taken
- pred_target, output, PROG_CTR_WID, predicted target (0 when pred_taken=0)
- upd_valid, input, 1, EX branch resolved this cycle
- upd_pc, input, PROG_CTR_WID, PC of the resolved branch
- upd_taken, input, 1, actual outcome
- upd_target, input, PROG_CTR_WID, actual target
- upd_pred_taken, input, 1, prediction carried down the pipeline
- upd_pred_target, input, PROG_CTR_WID, predicted target carried down the pipeline
- flush, output, 1, mispredict; invalidate IF/ID
- redirect_pc, output, PROG_CTR_WID, corrected PC, valid when flush=1
- clr_req, input, 1, start a table sweep-clear
- clr_busy, output, 1, sweep in progress
- lookup_cnt, output, STAT_WID, count of accepted lookups
- mispred_cnt, output, STAT_WID, count of mispredicts

## Operation
- Index is `pc[IDX-1:0]`, where IDX = clog2(BHT_DEPTH). Tag is `pc[PROG_CTR_WID-1:IDX]`.
- Each entry holds valid, tag, target (PROG_CTR_WID bits) and ctr (CTR_WID bits).
- Lookup hit = valid and tag match. pred_taken = hit & ctr MSB & lkp_valid & !clr_busy.
- Update on upd_valid & !clr_busy:
  - Hit: ctr saturating +1 if taken, -1 if not taken. Target is overwritten if taken.
  - Miss and taken: allocate the entry with valid=1, tag, target, and ctr=WT. WT = 2^(CTR_WID-1).
  - Miss and not taken: no change.
- flush = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
  - flush is evaluated even while clr_busy is high.
- redirect_pc = upd_taken ? upd_target : upd_pc+1, wrapping modulo 2^PROG_CTR_WID.
- FSM states:
  - IDLE: clr_req moves to CLEAR with ptr=0.
  - CLEAR: invalidates entry ptr once per cycle. When ptr=BHT_DEPTH-1, moves to IDLE.
  - clr_busy = (state==CLEAR). clr_req is ignored while in CLEAR.
- Stat counters saturate at all-ones.
  - lookup_cnt increments on lkp_valid & !clr_busy.
  - mispred_cnt increments on flush.
- Reset (asserted low, at any time, including mid-sweep):
  - All entries invalid, ctr=WT-1, tag/target=0.
  - State IDLE, ptr=0, counters 0.
  - Outputs 0, except redirect_pc, which follows inputs.

## Timing
- Lookup is combinational: zero-cycle latency from lkp_pc to pred_taken/pred_target.
- flush/redirect_pc are combinational from the upd_* inputs in the same cycle.
- A table write takes effect at the next rising edge. A lookup to the same index in the update cycle returns pre-update contents; there is no bypass.
- Sweep lasts exactly BHT_DEPTH cycles after the clr_req edge. Lookups and updates resume in the cycle after clr_busy falls.
- Simultaneous upd_valid with clr_req in IDLE: the update is applied and the sweep starts next cycle.
- Stat counters update at the edge after the qualifying cycle.

## Structure
- Shared package `proc_pkg`: clog2 function, and the WT/WNT counter-init constants derived from CTR_WID.
- One sub-module, `bht_sat_ctr`: combinational saturating up/down next-state for a CTR_WID counter. It is instantiated once on the update path.
- Table storage is a flop array so that the asynchronous reset clears it; there is no RAM macro.

## Test plan
- Reset release, lkp_pc=0x005 -> pred_taken=0, pred_target=0, all counters 0, clr_busy=0.
- Update pc=0x005, taken, target=0x120, pred_taken=0 -> flush=1, redirect_pc=0x120. Next-cycle lookup 0x005 gives pred_taken=1, target=0x120, and mispred_cnt=1.
- Same branch not taken twice (CTR_WID=2) -> ctr 2→1→0; lookup gives pred_taken=0. A fourth taken update saturates at 3 after ≥2 increments.
- Aliasing: update 0x015 taken (same index as 0x005 with BHT_DEPTH=16) -> lookup 0x005 misses; 0x015 hits.
- Not-taken mispredict at pc=0x3FF -> redirect_pc=0x000 (wrap).
- clr_req with a populated table -> clr_busy high for exactly 16 cycles, updates ignored, all lookups miss afterwards. Reset asserted at cycle 5 of the sweep -> IDLE immediately.
